// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, through a
// single full-adder cell. Result, cout and overflow update only on completion.

module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);
  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);
endmodule

module serial_addsub #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_sr, b_sr;
  logic [WIDTH-1:1]   res_sr;
  logic [WIDTH-1:0]   res_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               carry_q;
  logic               fa_s, fa_cout;
  logic               load, running, last_bit;
  logic [WIDTH-1:0]   result_q;
  logic               cout_q, ovf_q;

  full_adder u_fa (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Cin  (carry_q),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  // Start is honoured only outside RUN, so an operation in flight is never disturbed
  assign running  = (state == RUN);
  assign load     = (state != RUN) && start;
  assign last_bit = running && (cnt == CNT_W'(WIDTH - 1));
  assign res_nxt  = {fa_s, res_sr};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      carry_q  <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        carry_q <= sub;
        cnt     <= '0;
      end else if (running) begin
        carry_q <= fa_cout;
        cnt     <= cnt + CNT_W'(1);
        if (last_bit) begin
          result_q <= res_nxt;
          cout_q   <= fa_cout;
          ovf_q    <= carry_q ^ fa_cout;
        end
      end
    end
  end

  // Operand/partial-result shifters carry no reset; they are reloaded on every start
  always_ff @(posedge clock) begin
    if (load) begin
      a_sr <= a;
      b_sr <= sub ? ~b : b;
    end else if (running) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      res_sr <= res_nxt[WIDTH-1:1];
    end
  end

  assign busy     = running;
  assign done     = (state == DONE);
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=32): vector table plus
// corner-case sequences, with a queue-based scoreboard of expected results.

module tb_serial_addsub;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, overflow;
  logic [W-1:0] result;

  serial_addsub #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t         sb_q[$];
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] prev_result = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic vec_t model(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs);
    vec_t v;
    logic [W:0] s;
    logic [W-1:0] opb;
    opb = vs ? ~vb : vb;
    s = {1'b0, va} + {1'b0, opb} + {{W{1'b0}}, vs};
    v.a = va; v.b = vb; v.sub = vs;
    v.res = s[W-1:0];
    v.co  = s[W];
    v.ov  = vs ? ((va[W-1] != vb[W-1]) && (s[W-1] != va[W-1]))
               : ((va[W-1] == vb[W-1]) && (s[W-1] != va[W-1]));
    return v;
  endfunction

  // Called at a negedge; drives start for one cycle and pushes the expectation.
  task automatic drive_start(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs,
                             input exp_t e);
    a = va; b = vb; sub = vs; start = 1'b1;
    sb_q.push_back(e);
    @(negedge clock);
    start = 1'b0;
  endtask

  // Waits for done (bounded), checks latency, busy length, hold, and scoreboard.
  task automatic wait_and_check(input string name, input int inject_at,
                                input logic [W-1:0] ia, input logic [W-1:0] ib);
    int cycles = 0;
    int busy_cnt = 0;
    logic hold_ok = 1'b1;
    exp_t e;
    while (!done && cycles < 100) begin
      if (busy) busy_cnt++;
      if (result !== prev_result) hold_ok = 1'b0;
      if (cycles == inject_at) begin
        a = ia; b = ib; sub = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      cycles++;
    end
    start = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL %s timeout: no done after %0d cycles, expected %0d", name, cycles, W);
      return;
    end
    check({name, " latency"}, W'(cycles), W'(W));
    check({name, " busy_cycles"}, W'(busy_cnt), W'(W));
    check({name, " hold"}, {31'b0, hold_ok}, 32'd1);
    check({name, " busy_in_done"}, {31'b0, busy}, 32'd0);
    if (sb_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s scoreboard: got done with empty queue, expected entry", name);
    end else begin
      e = sb_q.pop_front();
      check({name, " result"}, result, e.res);
      check({name, " cout"}, {31'b0, cout}, {31'b0, e.co});
      check({name, " overflow"}, {31'b0, overflow}, {31'b0, e.ov});
    end
    prev_result = result;
  endtask

  task automatic run_op(input string name, input vec_t v);
    exp_t e;
    e.res = v.res; e.co = v.co; e.ov = v.ov;
    drive_start(v.a, v.b, v.sub, e);
    wait_and_check(name, -1, '0, '0);
    @(negedge clock);
    check({name, " done_pulse"}, {31'b0, done}, 32'd0);
    check({name, " stable"}, result, prev_result);
  endtask

  initial begin
    vec_t vt[12];
    vec_t v;
    exp_t e;
    int   n;
    logic saw_done;

    vt[0] = '{32'd5,        32'd3, 1'b0, 32'd8,        1'b0, 1'b0};
    vt[1] = '{32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vt[2] = '{32'hFFFFFFFF, 32'd1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vt[3] = '{32'd5,        32'd7, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vt[4] = '{32'h80000000, 32'd1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vt[5] = '{32'h80000000, 32'h80000000, 1'b0, 32'h0, 1'b1, 1'b1};
    vt[6] = '{32'd0,        32'd0, 1'b1, 32'h0,        1'b1, 1'b0};
    vt[7] = '{32'd9,        32'd9, 1'b1, 32'h0,        1'b1, 1'b0};
    for (int i = 8; i < 12; i++)
      vt[i] = model($urandom, $urandom, 1'($urandom_range(0, 1)));

    // Reset state
    #12;
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    check("rst result", result, 32'd0);
    check("rst flags", {30'b0, cout, overflow}, 32'd0);

    // Start accepted at the first edge after release
    @(negedge clock);
    reset_n = 1'b1;
    run_op("first", vt[0]);

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vt[i]);

    // Start pulse mid-RUN with different operands must be ignored
    v = model(32'd100, 32'd23, 1'b0);
    e.res = v.res; e.co = v.co; e.ov = v.ov;
    drive_start(v.a, v.b, v.sub, e);
    wait_and_check("midstart", 9, 32'h12345678, 32'h11111111);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (busy || done) saw_done = 1'b1;
    end
    check("midstart ignored", {31'b0, saw_done}, 32'd0);
    check("midstart queue", W'(sb_q.size()), 32'd0);

    // Back-to-back: start during the DONE cycle
    v = model(32'h0000FFFF, 32'h00000001, 1'b0);
    e.res = v.res; e.co = v.co; e.ov = v.ov;
    drive_start(v.a, v.b, v.sub, e);
    wait_and_check("b2b_1", -1, '0, '0);
    v = model(32'h00000010, 32'h00000020, 1'b1);
    e.res = v.res; e.co = v.co; e.ov = v.ov;
    drive_start(v.a, v.b, v.sub, e);
    check("b2b done_one_cycle", {30'b0, busy, done}, 32'd2);
    wait_and_check("b2b_2", 0, '0, '0);
    @(negedge clock);

    // Reset mid-RUN aborts the operation
    v = model(32'hDEADBEEF, 32'h01020304, 1'b0);
    e.res = v.res; e.co = v.co; e.ov = v.ov;
    drive_start(v.a, v.b, v.sub, e);
    for (int i = 0; i < 15; i++) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("abort busy_done", {30'b0, busy, done}, 32'd0);
    check("abort result", result, 32'd0);
    check("abort flags", {30'b0, cout, overflow}, 32'd0);
    void'(sb_q.pop_back());
    prev_result = '0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done || busy) saw_done = 1'b1;
    end
    check("abort no_done", {31'b0, saw_done}, 32'd0);
    n = 0;
    run_op("after_abort", model(32'hDEADBEEF, 32'h01020304, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
